lcd_host: RTL and testbench
===========================

# lcd_host

Host-side command sequencer for the 6x6 LCD window controller: the initiator that drives `cmd`/`cmd_valid`/`datain` and consumes `busy`/`dataout`/`output_valid`. Accepts high-level ops from an upstream engine, buffers a 36-pixel image, issues the command to the controller, and collects the returned 3x3 window into a register bank. Sits between the image-processing front end and the LCD controller.

## Interface

- `TIMEOUT`, default 255: maximum cycles from command issue to window completion before `err` is raised.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `op`  in  3  requested command: 0 REFLASH, 1 LOAD, 2 RIGHT, 3 LEFT, 4 UP, 5 DOWN; 6 and 7 are illegal.
- `op_valid`  in  1  upstream op request.
- `op_ready`  out  1  host idle and able to accept an op.
- `pix_in`  in  8  upstream pixel, raster order, row-major.
- `pix_valid`  in  1  pixel qualifier.
- `pix_ready`  out  1  high only in FILL.
- `cmd`  out  3  command to the controller.
- `cmd_valid`  out  1  command strobe, one cycle.
- `datain`  out  8  pixel to the controller during LOAD streaming.
- `busy`  in  1  controller busy.
- `dataout`  in  8  controller window byte.
- `output_valid`  in  1  `dataout` qualifier.
- `win_data`  out  72  captured window; byte k is at bits [8k+7:8k], k=0..8 in arrival order.
- `win_sum`  out  12  unsigned sum of the 9 window bytes.
- `win_valid`  out  1  one-cycle pulse when a window is complete.
- `err`  out  1  sticky error flag; cleared when the next op is accepted.

## Operation

- FSM states: IDLE, FILL, ISSUE, STREAM, WAIT_HI, COLLECT, DONE.
- IDLE: `op_ready`=1. Handshake `op_valid&&op_ready`: latch op, clear `err`, `win_sum`, and byte count. Next state is FILL for LOAD, otherwise ISSUE.
- Illegal op (6, 7): accepted, `err`=1, then return to IDLE. No command is issued.
- FILL: `pix_ready`=1. Each `pix_valid` writes buffer[idx] and increments idx (6-bit). After the 36th pixel (idx=35 accepted), go to ISSUE. Pixel gaps are allowed.
- ISSUE: entered only when `busy`=0; otherwise wait. Drive `cmd_valid`=1 and `cmd`=op for exactly one cycle. Next state is STREAM if LOAD, else WAIT_HI.
- STREAM: `datain`=buffer[k] for k=0..35 on 36 consecutive cycles, starting the cycle after `cmd_valid`. There are no gaps. Then go to WAIT_HI.
- WAIT_HI: wait for `busy`=1 or `output_valid`=1, then go to COLLECT.
- COLLECT: each `output_valid` cycle stores `dataout` into byte slot cnt, adds it to `win_sum`, and increments cnt (4-bit, saturating at 9). When `busy` falls to 0, go to DONE.
  - If cnt≠9 on exit, set `err`=1.
  - A 10th or later byte is ignored and sets `err`.
- DONE: pulse `win_valid` for one cycle, then go to IDLE.
- Timeout counter (8-bit, saturating) runs from ISSUE through COLLECT. Reaching TIMEOUT sets `err`=1, forces DONE, and pulses `win_valid` with whatever was captured.
- `win_sum` width: max is 9×255 = 2295, which fits in 12 bits, so there is no overflow.
- `win_data` holds its value until the next window's first byte overwrites it.

## Timing

- Reset values:
  - state IDLE; `op_ready`=1; `pix_ready`=0.
  - `cmd`=0, `cmd_valid`=0, `datain`=0.
  - `win_data`=0, `win_sum`=0, `win_valid`=0, `err`=0.
  - idx, cnt, and timeout counter = 0.
- All outputs are registered.
- `op_ready` drops the cycle after acceptance.
- LOAD latency from acceptance: 36 FILL cycles minimum + 1 ISSUE + 36 STREAM, then controller-dependent.
- `win_valid` asserts the cycle after `busy` is sampled low in COLLECT.
- `datain` is 0 outside STREAM.
- `cmd` holds its last value; it is meaningful only with `cmd_valid`.
- Reset mid-operation returns everything to reset values immediately. A partially filled buffer is discarded and no `cmd_valid` is issued.
- `op_valid` while not IDLE is ignored, since `op_ready`=0.

## Test plan

- Reset mid-STREAM -> `cmd_valid`/`datain` go 0 immediately, state returns to IDLE, `op_ready`=1, `err`=0.
- LOAD with pixels 0..35, one per cycle -> a single `cmd_valid` with `cmd`=1, then `datain` 0,1,…,35 on consecutive cycles. Controller model returns window 14,15,16,20,21,22,26,27,28 -> `win_sum`=189, `win_valid` pulse, `err`=0.
- LOAD with random `pix_valid` gaps -> STREAM is still 36 gapless cycles with identical data ordering.
- RIGHT after LOAD while model holds `busy` high 5 extra cycles -> `cmd_valid` is delayed until `busy`=0. `cmd`=2. Window 15,16,17,21,22,23,27,28,29 gives `win_sum`=198.
- Model returns only 8 bytes, then `busy`=0 -> `win_valid` pulse, `err`=1. `err` clears on the next accepted op.
- Model never raises `busy` and never outputs (TIMEOUT=20) -> `err`=1 and `win_valid` exactly 20 cycles after `cmd_valid`. `op`=7 -> `err`=1 with no `cmd_valid`.

Source files
------------

// File: rtl/lcd_host.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_host
//  Description : Host-side command sequencer for the 6x6 LCD window
//                controller. Accepts high-level ops from an upstream engine,
//                buffers a 36-pixel image for LOAD, issues the command to the
//                controller, streams the image, and collects the returned
//                3x3 window (bytes plus their sum) into output registers.
//
//  Ports
//    clk, reset          : clock; asynchronous active-high reset
//    op, op_valid        : upstream op request (0 REFLASH .. 5 DOWN)
//    op_ready            : host idle, op will be accepted
//    pix_in, pix_valid   : upstream raster-order pixels for LOAD
//    pix_ready           : host is collecting pixels
//    cmd, cmd_valid      : one-cycle command strobe to the controller
//    datain              : image stream to the controller after LOAD
//    busy                : controller busy
//    dataout,output_valid: window bytes returned by the controller
//    win_data, win_sum   : captured window bytes and their unsigned sum
//    win_valid           : one-cycle pulse when a window is complete
//    err                 : sticky error, cleared on the next accepted op
//
//  Revision    : 1.0  initial release
// ============================================================================
module lcd_host #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  op,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [7:0]  pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [2:0]  cmd,
    output logic        cmd_valid,
    output logic [7:0]  datain,
    input  logic        busy,
    input  logic [7:0]  dataout,
    input  logic        output_valid,
    output logic [71:0] win_data,
    output logic [11:0] win_sum,
    output logic        win_valid,
    output logic        err
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_STREAM  = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_COLLECT = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    localparam logic [2:0] OP_LOAD   = 3'd1;
    localparam logic [2:0] OP_MAX    = 3'd5;
    localparam logic [5:0] LAST_PIX  = 6'd35;
    localparam logic [3:0] WIN_BYTES = 4'd9;
    // The counter starts at 0 on the issue cycle, so the limit is hit when
    // it reads TIMEOUT-1; the forced completion then lands TIMEOUT cycles
    // after cmd_valid.
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [2:0]  op_q;
    logic [5:0]  idx_q;
    logic [3:0]  cnt_q;
    logic [7:0]  tmo_q;
    logic [7:0]  pix_buf_q [36];

    logic        op_ready_q;
    logic        pix_ready_q;
    logic [2:0]  cmd_q;
    logic        cmd_valid_q;
    logic [7:0]  datain_q;
    logic [71:0] win_data_q;
    logic [11:0] win_sum_q;
    logic        win_valid_q;
    logic        err_q;

    // A returned byte is kept only while fewer than nine have been stored.
    logic        byte_take;
    logic [3:0]  cnt_d;
    logic [7:0]  tmo_d;
    logic        tmo_hit;

    assign byte_take = output_valid && (cnt_q != WIN_BYTES);
    assign cnt_d     = byte_take ? (cnt_q + 4'd1) : cnt_q;
    assign tmo_d     = (tmo_q == 8'hFF) ? tmo_q : (tmo_q + 8'd1);
    assign tmo_hit   = (tmo_q == TMO_LAST);

    // Pixel buffer carries no reset: its contents are only ever read after
    // a complete FILL has rewritten all 36 entries.
    always_ff @(posedge clk) begin
        if (state_q == ST_FILL && pix_valid) begin
            pix_buf_q[idx_q] <= pix_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= 3'd0;
            idx_q       <= 6'd0;
            cnt_q       <= 4'd0;
            tmo_q       <= 8'd0;
            op_ready_q  <= 1'b1;
            pix_ready_q <= 1'b0;
            cmd_q       <= 3'd0;
            cmd_valid_q <= 1'b0;
            datain_q    <= 8'd0;
            win_data_q  <= 72'd0;
            win_sum_q   <= 12'd0;
            win_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // Strobes and the stream byte fall back to 0 unless driven below.
            cmd_valid_q <= 1'b0;
            win_valid_q <= 1'b0;
            datain_q    <= 8'd0;

            case (state_q)
                ST_IDLE: begin
                    if (op_valid && op_ready_q) begin
                        op_q      <= op;
                        err_q     <= 1'b0;
                        win_sum_q <= 12'd0;
                        cnt_q     <= 4'd0;
                        idx_q     <= 6'd0;
                        tmo_q     <= 8'd0;
                        if (op > OP_MAX) begin
                            // Illegal op: flag it and stay idle, nothing issued.
                            err_q <= 1'b1;
                        end else if (op == OP_LOAD) begin
                            op_ready_q  <= 1'b0;
                            pix_ready_q <= 1'b1;
                            state_q     <= ST_FILL;
                        end else begin
                            op_ready_q <= 1'b0;
                            state_q    <= ST_ISSUE;
                        end
                    end
                end

                ST_FILL: begin
                    if (pix_valid) begin
                        idx_q <= idx_q + 6'd1;
                        if (idx_q == LAST_PIX) begin
                            pix_ready_q <= 1'b0;
                            state_q     <= ST_ISSUE;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (!busy) begin
                        cmd_valid_q <= 1'b1;
                        cmd_q       <= op_q;
                        tmo_q       <= 8'd0;
                        idx_q       <= 6'd0;
                        state_q     <= (op_q == OP_LOAD) ? ST_STREAM : ST_WAIT_HI;
                    end else begin
                        // A controller stuck busy must not hang the host.
                        tmo_q <= tmo_d;
                        if (tmo_hit) begin
                            err_q       <= 1'b1;
                            win_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end

                ST_STREAM: begin
                    datain_q <= pix_buf_q[idx_q];
                    idx_q    <= idx_q + 6'd1;
                    tmo_q    <= tmo_d;
                    if (tmo_hit) begin
                        err_q       <= 1'b1;
                        win_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else if (idx_q == LAST_PIX) begin
                        state_q <= ST_WAIT_HI;
                    end
                end

                ST_WAIT_HI, ST_COLLECT: begin
                    // Bytes are captured in WAIT_HI as well so that a
                    // controller answering without raising busy first loses
                    // nothing.
                    if (byte_take) begin
                        for (int k = 0; k < 9; k++) begin
                            if (cnt_q == 4'(k)) begin
                                win_data_q[8*k +: 8] <= dataout;
                            end
                        end
                        win_sum_q <= win_sum_q + 12'(dataout);
                        cnt_q     <= cnt_d;
                    end else if (output_valid) begin
                        err_q <= 1'b1;
                    end
                    tmo_q <= tmo_d;
                    if (tmo_hit) begin
                        err_q       <= 1'b1;
                        win_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else if (state_q == ST_WAIT_HI) begin
                        if (busy || output_valid) begin
                            state_q <= ST_COLLECT;
                        end
                    end else if (!busy) begin
                        win_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                        if (cnt_d != WIN_BYTES) begin
                            err_q <= 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    op_ready_q <= 1'b1;
                    state_q    <= ST_IDLE;
                end

                default: begin
                    op_ready_q  <= 1'b1;
                    pix_ready_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign op_ready  = op_ready_q;
    assign pix_ready = pix_ready_q;
    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign datain    = datain_q;
    assign win_data  = win_data_q;
    assign win_sum   = win_sum_q;
    assign win_valid = win_valid_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lcd_host
//  Description : Self-checking bench for lcd_host. A behavioural LCD
//                controller (image array + window position) answers the
//                host; expected windows, sums and error flags are derived
//                from that model. A second instance with a short timeout
//                exercises the timeout path.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lcd_host;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [2:0]  op = 3'd0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [7:0]  pix_in = 8'd0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic [2:0]  cmd;
    logic        cmd_valid;
    logic [7:0]  datain;
    logic        busy = 1'b0;
    logic [7:0]  dataout = 8'd0;
    logic        output_valid = 1'b0;
    logic [71:0] win_data;
    logic [11:0] win_sum;
    logic        win_valid;
    logic        err;

    logic [2:0]  op_t = 3'd0;
    logic        op_valid_t = 1'b0;
    logic        op_ready_t;
    logic        pix_ready_t;
    logic [2:0]  cmd_t;
    logic        cmd_valid_t;
    logic [7:0]  datain_t;
    logic [71:0] win_data_t;
    logic [11:0] win_sum_t;
    logic        win_valid_t;
    logic        err_t;
    logic [7:0]  zero8 = 8'd0;
    logic        zero1 = 1'b0;

    lcd_host #(.TIMEOUT(255)) dut (
        .clk(clk), .reset(reset),
        .op(op), .op_valid(op_valid), .op_ready(op_ready),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .cmd(cmd), .cmd_valid(cmd_valid), .datain(datain),
        .busy(busy), .dataout(dataout), .output_valid(output_valid),
        .win_data(win_data), .win_sum(win_sum), .win_valid(win_valid), .err(err)
    );

    lcd_host #(.TIMEOUT(20)) dut_t (
        .clk(clk), .reset(reset),
        .op(op_t), .op_valid(op_valid_t), .op_ready(op_ready_t),
        .pix_in(zero8), .pix_valid(zero1), .pix_ready(pix_ready_t),
        .cmd(cmd_t), .cmd_valid(cmd_valid_t), .datain(datain_t),
        .busy(zero1), .dataout(zero8), .output_valid(zero1),
        .win_data(win_data_t), .win_sum(win_sum_t), .win_valid(win_valid_t), .err(err_t)
    );

    int checks = 0;
    int errors = 0;
    int cmd_seen = 0;

    logic [7:0]  img      [36];   // image fed to the host
    logic [7:0]  ctrl_img [36];   // image held by the controller model
    int          pos_r = 0;
    int          pos_c = 0;
    logic [71:0] exp_win_data = 72'd0;

    always @(negedge clk) begin
        if (cmd_valid === 1'b1) cmd_seen++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept_op(input logic [2:0] o);
        int n = 0;
        while (op_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("op_ready_idle", op_ready, 1'b1);
        op = o;
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        if (o > 3'd5) begin
            check("illegal_err", err, 1'b1);
            check("illegal_op_ready", op_ready, 1'b1);
        end else begin
            check("op_ready_drop", op_ready, 1'b0);
            check("err_clear", err, 1'b0);
            check("pix_ready_fill", pix_ready, (o == 3'd1));
        end
    endtask

    task automatic feed_pixels(input bit gaps);
        int n = 0;
        int guard = 0;
        bit pv;
        logic rdy;
        while (n < 36 && guard < 1000) begin
            pv = !(gaps && $urandom_range(0, 2) == 0);
            pix_valid = pv;
            pix_in = pv ? img[n] : 8'($urandom);
            rdy = pix_ready;
            @(negedge clk);
            if (pv && rdy === 1'b1) n++;
            guard++;
        end
        pix_valid = 1'b0;
        check("fill_count", n, 36);
        check("pix_ready_after_fill", pix_ready, 1'b0);
    endtask

    // Behavioural controller: waits for the command, swallows the LOAD
    // stream, moves the window, returns nbytes bytes, then drops busy.
    task automatic controller(input logic [2:0] o, input int nbytes, input int gap_max);
        int n = 0;
        int sum = 0;
        logic [7:0] win [9];
        logic [7:0] b;
        while (cmd_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_valid_seen", cmd_valid, 1'b1);
        check("cmd_value", cmd, o);
        busy = 1'b1;
        if (o == 3'd1) begin
            for (int k = 0; k < 36; k++) begin
                @(negedge clk);
                if (k == 0) check("cmd_valid_single", cmd_valid, 1'b0);
                check("stream_data", datain, img[k]);
                ctrl_img[k] = img[k];
            end
            @(negedge clk);
            check("datain_idle", datain, 8'd0);
            pos_r = 2;
            pos_c = 2;
        end else begin
            @(negedge clk);
            check("cmd_valid_single", cmd_valid, 1'b0);
            if (o == 3'd2 && pos_c < 3) pos_c++;
            if (o == 3'd3 && pos_c > 0) pos_c--;
            if (o == 3'd4 && pos_r > 0) pos_r--;
            if (o == 3'd5 && pos_r < 3) pos_r++;
        end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                win[r*3+c] = ctrl_img[(pos_r + r) * 6 + pos_c + c];
        for (int i = 0; i < nbytes; i++) begin
            int g;
            g = int'($urandom_range(0, gap_max));
            repeat (g) begin
                output_valid = 1'b0;
                @(negedge clk);
            end
            b = (i < 9) ? win[i] : 8'($urandom);
            output_valid = 1'b1;
            dataout = b;
            @(negedge clk);
            if (i < 9) begin
                sum += int'(b);
                exp_win_data[8*i +: 8] = b;
            end
        end
        output_valid = 1'b0;
        dataout = 8'd0;
        busy = 1'b0;
        @(negedge clk);
        check("win_valid_pulse", win_valid, 1'b1);
        check("win_sum", win_sum, sum);
        check("win_data", win_data, exp_win_data);
        check("err_byte_count", err, (nbytes != 9));
        @(negedge clk);
        check("win_valid_one_cycle", win_valid, 1'b0);
    endtask

    initial begin
        int n;
        int base;
        logic [2:0] o;
        int nb;

        // ---------------- reset values ----------------
        @(negedge clk);
        check("rst_op_ready", op_ready, 1'b1);
        check("rst_pix_ready", pix_ready, 1'b0);
        check("rst_cmd", cmd, 3'd0);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_datain", datain, 8'd0);
        check("rst_win_data", win_data, 72'd0);
        check("rst_win_sum", win_sum, 12'd0);
        check("rst_win_valid", win_valid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_t_op_ready", op_ready_t, 1'b1);
        check("rst_t_err", err_t, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // ---------------- LOAD 0..35, no gaps ----------------
        for (int k = 0; k < 36; k++) img[k] = 8'(k);
        accept_op(3'd1);
        feed_pixels(1'b0);
        controller(3'd1, 9, 0);
        check("load_sum_189", win_sum, 12'd189);
        check("load_err", err, 1'b0);

        // ---------------- RIGHT held off by busy ----------------
        busy = 1'b1;
        accept_op(3'd2);
        for (int i = 0; i < 5; i++) begin
            check("cmd_held_busy", cmd_valid, 1'b0);
            @(negedge clk);
        end
        busy = 1'b0;
        controller(3'd2, 9, 0);
        check("right_sum_198", win_sum, 12'd198);

        // ---------------- short window, then err clears ----------------
        controller_short: begin
            accept_op(3'd0);
            controller(3'd0, 8, 1);
            check("short_err_sticky", err, 1'b1);
        end
        accept_op(3'd3);
        controller(3'd3, 9, 2);

        // ---------------- illegal op ----------------
        accept_op(3'd7);
        base = cmd_seen;
        repeat (6) @(negedge clk);
        check("illegal_no_cmd", cmd_seen, base);
        check("illegal_err_hold", err, 1'b1);

        // ---------------- LOAD with pixel gaps ----------------
        for (int k = 0; k < 36; k++) img[k] = 8'($urandom);
        accept_op(3'd1);
        feed_pixels(1'b1);
        controller(3'd1, 9, 3);

        // ---------------- randomized ops ----------------
        for (int it = 0; it < 10; it++) begin
            o = 3'($urandom_range(0, 5));
            case ($urandom_range(0, 3))
                0:       nb = 8;
                3:       nb = 10;
                default: nb = 9;
            endcase
            if (o == 3'd1) begin
                for (int k = 0; k < 36; k++) img[k] = 8'($urandom);
                accept_op(o);
                feed_pixels(1'($urandom_range(0, 1)));
            end else begin
                accept_op(o);
            end
            controller(o, nb, int'($urandom_range(0, 2)));
        end

        // ---------------- timeout (TIMEOUT=20 instance) ----------------
        @(negedge clk);
        op_t = 3'd2;
        op_valid_t = 1'b1;
        @(negedge clk);
        op_valid_t = 1'b0;
        n = 0;
        while (cmd_valid_t !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t_cmd_valid", cmd_valid_t, 1'b1);
        check("t_cmd", cmd_t, 3'd2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (win_valid_t !== 1'b1 && n < 60);
        check("timeout_latency", n, 20);
        check("timeout_err", err_t, 1'b1);
        check("timeout_sum", win_sum_t, 12'd0);

        // ---------------- reset mid-STREAM ----------------
        for (int k = 0; k < 36; k++) img[k] = 8'(k + 100);
        accept_op(3'd1);
        feed_pixels(1'b0);
        n = 0;
        while (cmd_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        busy = 1'b1;
        repeat (3) @(negedge clk);
        check("stream_before_reset", datain, img[2]);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_cmd_valid", cmd_valid, 1'b0);
        check("mid_rst_datain", datain, 8'd0);
        check("mid_rst_op_ready", op_ready, 1'b1);
        check("mid_rst_err", err, 1'b0);
        check("mid_rst_pix_ready", pix_ready, 1'b0);
        check("mid_rst_win_sum", win_sum, 12'd0);
        busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        exp_win_data = 72'd0;
        check("mid_rst_win_data", win_data, exp_win_data);
        base = cmd_seen;
        repeat (40) @(negedge clk);
        check("mid_rst_no_cmd", cmd_seen, base);
        check("mid_rst_idle", op_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
